// File: rtl/riio_pad_seq_pkg.sv
// riio_pad_seq_pkg: shared types and constants for the IO-ring pad power-up sequencer.
package riio_pad_seq_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DEBOUNCE  = 3'd1,
    RAMP_UP   = 3'd2,
    ON        = 3'd3,
    RAMP_DOWN = 3'd4
  } pad_seq_state_e;

  // Width of the optional power-drop event counter
  localparam int DROP_CNT_W = 8;

  // Larger of two integers, used to size the shared cycle counter
  function automatic int max_int(input int a, input int b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/riio_sync2.sv
// riio_sync2: generic two-flop synchroniser, async active-low reset, resets to 0.
module riio_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;

  // Two back-to-back flops to resolve metastability on the asynchronous input
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_r <= '0;
      sync_r <= '0;
    end else begin
      meta_r <= d_i;
      sync_r <= meta_r;
    end
  end

  assign q_o = sync_r;

endmodule

// File: rtl/riio_pad_seq.sv
// riio_pad_seq: IO-ring pad power-up sequencer. Debounces VDDIO power-good, then
// enables the input buffers and releases output-enable groups one at a time to
// limit simultaneous switching current. Power loss drops everything at once;
// a software disable ramps the groups down in reverse order.
// Optional feature macro: RIIO_PAD_SEQ_STATUS_EN adds a saturating drop counter
// (clr_cnt_i / drop_cnt_o).
module riio_pad_seq
  import riio_pad_seq_pkg::*;
#(
  parameter int N_GROUPS     = 4,
  parameter int DEBOUNCE_CYC = 16,
  parameter int STAGGER_CYC  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic                  io_pwr_ok_i,
`ifdef RIIO_PAD_SEQ_STATUS_EN
  input  logic                  clr_cnt_i,
  output logic [DROP_CNT_W-1:0] drop_cnt_o,
`endif
  output logic [N_GROUPS-1:0]   grp_oe_en_o,
  output logic                  ie_en_o,
  output logic                  ready_o,
  output logic                  pwr_drop_o
);

  localparam int CNT_W = $clog2(max_int(DEBOUNCE_CYC, STAGGER_CYC) + 1);
  localparam int IDX_W = $clog2(N_GROUPS + 1);

  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] STG_RELOAD = CNT_W'(STAGGER_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_FULL   = IDX_W'(N_GROUPS);
  localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);

  // Thermometer mask with the lowest n bits set; keeps enabled groups contiguous from bit 0
  function automatic logic [N_GROUPS-1:0] thermo(input logic [IDX_W-1:0] n);
    logic [N_GROUPS-1:0] m;
    m = '0;
    for (int i = 0; i < N_GROUPS; i++) begin
      m[i] = (IDX_W'(i) < n);
    end
    return m;
  endfunction

  pad_seq_state_e      state_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [IDX_W-1:0]    idx_r;
  logic [N_GROUPS-1:0] grp_r;
  logic                ie_r;
  logic                ready_r;
  logic                drop_r;

  logic                pwr_ok_s;
  logic                drop_event_s;
  logic [IDX_W-1:0]    idx_inc_s;
  logic [IDX_W-1:0]    idx_dec_s;

  riio_sync2 #(.WIDTH(1)) u_pwr_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (io_pwr_ok_i),
    .q_o    (pwr_ok_s)
  );

  // Power loss while any pad is (being) enabled, and group-index neighbours
  always_comb begin
    drop_event_s = 1'b0;
    if (!pwr_ok_s &&
        ((state_r == RAMP_UP) || (state_r == ON) || (state_r == RAMP_DOWN))) begin
      drop_event_s = 1'b1;
    end else begin
      drop_event_s = 1'b0;
    end
    idx_inc_s = idx_r + IDX_ONE;
    idx_dec_s = idx_r - IDX_ONE;
  end

  // Sequencer FSM with registered pad controls; power loss takes priority over everything
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      idx_r   <= '0;
      grp_r   <= '0;
      ie_r    <= 1'b0;
      ready_r <= 1'b0;
      drop_r  <= 1'b0;
    end else if (drop_event_s) begin
      grp_r   <= '0;
      ie_r    <= 1'b0;
      ready_r <= 1'b0;
      drop_r  <= 1'b1;
      idx_r   <= '0;
      cnt_r   <= '0;
      if (en_i) begin
        state_r <= DEBOUNCE;
      end else begin
        state_r <= IDLE;
      end
    end else begin
      drop_r <= 1'b0;
      case (state_r)
        IDLE: begin
          grp_r   <= '0;
          ie_r    <= 1'b0;
          ready_r <= 1'b0;
          idx_r   <= '0;
          cnt_r   <= '0;
          if (en_i) begin
            state_r <= DEBOUNCE;
          end else begin
            state_r <= IDLE;
          end
        end
        DEBOUNCE: begin
          if (!en_i) begin
            state_r <= IDLE;
            cnt_r   <= '0;
          end else if (!pwr_ok_s) begin
            cnt_r <= '0;
          end else if (cnt_r == DEB_LAST) begin
            state_r <= RAMP_UP;
            ie_r    <= 1'b1;
            idx_r   <= IDX_ONE;
            grp_r   <= thermo(IDX_ONE);
            cnt_r   <= STG_RELOAD;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        RAMP_UP: begin
          if (!en_i) begin
            state_r <= RAMP_DOWN;
            ready_r <= 1'b0;
            idx_r   <= idx_dec_s;
            grp_r   <= thermo(idx_dec_s);
            cnt_r   <= STG_RELOAD;
          end else if (cnt_r != '0) begin
            cnt_r <= cnt_r - CNT_W'(1);
          end else if (idx_r == IDX_FULL) begin
            state_r <= ON;
            ready_r <= 1'b1;
          end else begin
            idx_r <= idx_inc_s;
            grp_r <= thermo(idx_inc_s);
            cnt_r <= STG_RELOAD;
          end
        end
        ON: begin
          if (!en_i) begin
            state_r <= RAMP_DOWN;
            ready_r <= 1'b0;
            idx_r   <= idx_dec_s;
            grp_r   <= thermo(idx_dec_s);
            cnt_r   <= STG_RELOAD;
          end else begin
            state_r <= ON;
          end
        end
        RAMP_DOWN: begin
          if (cnt_r != '0) begin
            cnt_r <= cnt_r - CNT_W'(1);
          end else if (idx_r == '0) begin
            ie_r    <= 1'b0;
            state_r <= IDLE;
          end else begin
            idx_r <= idx_dec_s;
            grp_r <= thermo(idx_dec_s);
            cnt_r <= STG_RELOAD;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
          idx_r   <= '0;
          grp_r   <= '0;
          ie_r    <= 1'b0;
          ready_r <= 1'b0;
        end
      endcase
    end
  end

  assign grp_oe_en_o = grp_r;
  assign ie_en_o     = ie_r;
  assign ready_o     = ready_r;
  assign pwr_drop_o  = drop_r;

`ifdef RIIO_PAD_SEQ_STATUS_EN
  logic [DROP_CNT_W-1:0] drop_cnt_r;

  // Saturating count of power-drop events; a clear wins over a coincident drop
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      drop_cnt_r <= '0;
    end else if (clr_cnt_i) begin
      drop_cnt_r <= '0;
    end else if (drop_event_s && (drop_cnt_r != {DROP_CNT_W{1'b1}})) begin
      drop_cnt_r <= drop_cnt_r + DROP_CNT_W'(1);
    end else begin
      drop_cnt_r <= drop_cnt_r;
    end
  end

  assign drop_cnt_o = drop_cnt_r;
`endif

endmodule

// File: tb/tb_riio_pad_seq.sv
// tb_riio_pad_seq: directed self-checking bench for riio_pad_seq (default parameters).
module tb_riio_pad_seq;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       pwr;
  logic [3:0] grp;
  logic       ie;
  logic       rdy;
  logic       drp;
`ifdef RIIO_PAD_SEQ_STATUS_EN
  logic       clr;
  logic [7:0] dcnt;
`endif

  int vectors;
  int miscompares;

  riio_pad_seq #(
    .N_GROUPS     (4),
    .DEBOUNCE_CYC (16),
    .STAGGER_CYC  (8)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .en_i        (en),
    .io_pwr_ok_i (pwr),
`ifdef RIIO_PAD_SEQ_STATUS_EN
    .clr_cnt_i   (clr),
    .drop_cnt_o  (dcnt),
`endif
    .grp_oe_en_o (grp),
    .ie_en_o     (ie),
    .ready_o     (rdy),
    .pwr_drop_o  (drp)
  );

  // free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pk(input logic [3:0] g, input logic i, input logic r, input logic d);
    return {25'd0, g, i, r, d};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [3:0] g, input logic i, input logic r, input logic d);
    check(tag, pk(grp, ie, rdy, drp), pk(g, i, r, d));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n = 1'b0;
    en    = 1'b0;
    pwr   = 1'b0;
`ifdef RIIO_PAD_SEQ_STATUS_EN
    clr   = 1'b0;
`endif
    step(2);
    chk_outs("reset", 4'h0, 1'b0, 1'b0, 1'b0);
`ifdef RIIO_PAD_SEQ_STATUS_EN
    check("reset_cnt", {24'd0, dcnt}, 32'd0);
`endif
    rst_n = 1'b1;
    step(1);

    // power-up with defaults
    en = 1'b1;
    step(1);
    pwr = 1'b1;
    step(17);
    chk_outs("pu_before_g0", 4'h0, 1'b0, 1'b0, 1'b0);
    step(1);
    chk_outs("pu_g0", 4'h1, 1'b1, 1'b0, 1'b0);
    step(7);
    chk_outs("pu_g0_hold", 4'h1, 1'b1, 1'b0, 1'b0);
    step(1);
    chk_outs("pu_g1", 4'h3, 1'b1, 1'b0, 1'b0);
    step(8);
    chk_outs("pu_g2", 4'h7, 1'b1, 1'b0, 1'b0);
    step(8);
    chk_outs("pu_g3", 4'hF, 1'b1, 1'b0, 1'b0);
    step(7);
    chk_outs("pu_before_ready", 4'hF, 1'b1, 1'b0, 1'b0);
    step(1);
    chk_outs("pu_ready", 4'hF, 1'b1, 1'b1, 1'b0);

    // software ramp-down from ON
    en = 1'b0;
    step(1);
    chk_outs("rd_entry", 4'h7, 1'b1, 1'b0, 1'b0);
    step(7);
    chk_outs("rd_hold", 4'h7, 1'b1, 1'b0, 1'b0);
    step(1);
    chk_outs("rd_g2", 4'h3, 1'b1, 1'b0, 1'b0);
    step(8);
    chk_outs("rd_g1", 4'h1, 1'b1, 1'b0, 1'b0);
    step(8);
    chk_outs("rd_g0", 4'h0, 1'b1, 1'b0, 1'b0);
    step(7);
    chk_outs("rd_ie_hold", 4'h0, 1'b1, 1'b0, 1'b0);
    step(1);
    chk_outs("rd_ie_off", 4'h0, 1'b0, 1'b0, 1'b0);

    // debounce glitch restarts the count
    pwr = 1'b0;
    step(3);
    en = 1'b1;
    step(1);
    pwr = 1'b1;
    step(11);
    pwr = 1'b0;
    step(1);
    pwr = 1'b1;
    step(17);
    chk_outs("glitch_no_g0", 4'h0, 1'b0, 1'b0, 1'b0);
    step(1);
    chk_outs("glitch_g0", 4'h1, 1'b1, 1'b0, 1'b0);
    step(8);
    chk_outs("glitch_g1", 4'h3, 1'b1, 1'b0, 1'b0);

    // power drop in RAMP_UP, coinciding with a group step
    step(5);
    pwr = 1'b0;
    step(2);
    chk_outs("drop_pending", 4'h3, 1'b1, 1'b0, 1'b0);
    step(1);
    chk_outs("drop_clear", 4'h0, 1'b0, 1'b0, 1'b1);
    step(1);
    chk_outs("drop_pulse_end", 4'h0, 1'b0, 1'b0, 1'b0);

    // re-debounce and ramp again from group 0
    pwr = 1'b1;
`ifdef RIIO_PAD_SEQ_STATUS_EN
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    step(16);
    check("cnt_cleared", {24'd0, dcnt}, 32'd0);
`else
    step(17);
`endif
    chk_outs("redeb_no_g0", 4'h0, 1'b0, 1'b0, 1'b0);
    step(1);
    chk_outs("redeb_g0", 4'h1, 1'b1, 1'b0, 1'b0);

    // en_i fall coincident with pwr_ok_s drop
    pwr = 1'b0;
    step(2);
    en = 1'b0;
    chk_outs("coinc_pending", 4'h1, 1'b1, 1'b0, 1'b0);
    step(1);
    chk_outs("coinc_clear", 4'h0, 1'b0, 1'b0, 1'b1);
`ifdef RIIO_PAD_SEQ_STATUS_EN
    check("coinc_cnt", {24'd0, dcnt}, 32'd1);
`endif
    step(1);
    chk_outs("coinc_pulse_end", 4'h0, 1'b0, 1'b0, 1'b0);

    // async reset mid-ramp-down
    pwr = 1'b1;
    en  = 1'b1;
    step(17);
    chk_outs("rst_pre_no_g0", 4'h0, 1'b0, 1'b0, 1'b0);
    step(1);
    chk_outs("rst_pre_g0", 4'h1, 1'b1, 1'b0, 1'b0);
    en = 1'b0;
    step(1);
    chk_outs("rst_rd_entry", 4'h0, 1'b1, 1'b0, 1'b0);
    step(3);
    #2;
    rst_n = 1'b0;
    #1;
    chk_outs("rst_async", 4'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(2);
    chk_outs("rst_after", 4'h0, 1'b0, 1'b0, 1'b0);

`ifdef RIIO_PAD_SEQ_STATUS_EN
    // drop counter saturation and clear
    en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      pwr = 1'b1;
      step(20);
      pwr = 1'b0;
      step(4);
    end
    check("cnt_sat", {24'd0, dcnt}, 32'd255);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    check("cnt_clr", {24'd0, dcnt}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
